// File: rtl/switch_scan_pkg.sv
// Shared types and parameter legality rules for the switch matrix scanner.
package switch_scan_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FRAME_END} scan_state_t;

   // Column decode is 3-to-8, so the grid can be at most 8x8.
   localparam int MAX_N = 8;

   function automatic bit scan_params_ok(input int n, input int settle, input int debounce);
      return (n >= 1) && (n <= MAX_N) && (settle >= 1) && (debounce >= 1);
   endfunction

endpackage

// File: rtl/decoder_3_to_8.sv
// Enabled 3-to-8 one-hot decoder, active-high outputs.
module decoder_3_to_8 (
   input  logic       en_i,
   input  logic [2:0] a_i,
   output logic [7:0] y_o
);

   always_comb begin
      y_o = 8'h00;
      if (en_i) y_o[a_i] = 1'b1;
   end

endmodule

// File: rtl/switch_matrix_scanner.sv
// Column-at-a-time switch matrix reader with whole-frame debounce; output layout
// matches the LED driver's cells vector (cells[N*row+col]).
module switch_matrix_scanner
   import switch_scan_pkg::*;
#(
   parameter int N               = 8,
   parameter int SETTLE_CYCLES   = 2,
   parameter int DEBOUNCE_FRAMES = 2,
   localparam int XBITS = $clog2(N),
   localparam int XW    = XBITS + 1,
   localparam int DW    = $clog2(DEBOUNCE_FRAMES + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            ena_i,
   output logic [N-1:0]    scan_cols_o,
   input  logic [N-1:0]    sense_rows_i,
   output logic [XW-1:0]   x_o,
   output logic [N*N-1:0]  cells_o,
   output logic            frame_done_o,
   output logic            cells_changed_o,
   output logic            busy_o,
   output logic [1:0]      state_o,
   output logic [DW-1:0]   stable_cnt_o
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [XW-1:0] X_LAST      = XW'(N - 1);
   localparam logic [DW-1:0] DB_MAX      = DW'(DEBOUNCE_FRAMES);

   if (!scan_params_ok(N, SETTLE_CYCLES, DEBOUNCE_FRAMES)) begin : g_bad_params
      $error("switch_matrix_scanner: illegal N / SETTLE_CYCLES / DEBOUNCE_FRAMES");
   end

   scan_state_t      state_q;
   logic [XW-1:0]    x_q;
   logic [SW-1:0]    settle_q;
   logic [DW-1:0]    stable_q;
   logic [N*N-1:0]   raw_q, prev_raw_q, cells_q;
   logic             cells_changed_q;

   logic [DW-1:0]    stable_d;
   logic             commit_d;
   logic [7:0]       dec_y;

   decoder_3_to_8 u_col_dec (
      .en_i (state_q == DRIVE || state_q == SAMPLE),
      .a_i  (3'(x_q)),
      .y_o  (dec_y)
   );

   // Stability count after this frame; saturates so long-held patterns never wrap.
   always_comb begin
      stable_d = DW'(1);
      if (raw_q == prev_raw_q) stable_d = (stable_q >= DB_MAX) ? DB_MAX : stable_q + DW'(1);
      commit_d = (stable_d >= DB_MAX);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q         <= IDLE;
         x_q             <= '0;
         settle_q        <= '0;
         stable_q        <= '0;
         raw_q           <= '0;
         prev_raw_q      <= '0;
         cells_q         <= '0;
         cells_changed_q <= 1'b0;
      end else begin
         cells_changed_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ena_i) begin
                  state_q  <= DRIVE;
                  x_q      <= '0;
                  settle_q <= '0;
               end
            end
            DRIVE: begin
               if (!ena_i) begin
                  state_q  <= IDLE;
                  x_q      <= '0;
                  settle_q <= '0;
                  stable_q <= '0;
               end else if (settle_q == SETTLE_LAST) begin
                  state_q <= SAMPLE;
               end else begin
                  settle_q <= settle_q + SW'(1);
               end
            end
            SAMPLE: begin
               if (!ena_i) begin
                  // Partial frame is dropped; debounce restarts from scratch.
                  state_q  <= IDLE;
                  x_q      <= '0;
                  settle_q <= '0;
                  stable_q <= '0;
               end else begin
                  for (int i = 0; i < N; i++) raw_q[N*i + int'(x_q)] <= ~sense_rows_i[i];
                  if (x_q == X_LAST) begin
                     state_q <= FRAME_END;
                  end else begin
                     x_q      <= x_q + XW'(1);
                     settle_q <= '0;
                     state_q  <= DRIVE;
                  end
               end
            end
            FRAME_END: begin
               x_q        <= '0;
               settle_q   <= '0;
               prev_raw_q <= raw_q;
               stable_q   <= stable_d;
               if (commit_d) begin
                  cells_q         <= raw_q;
                  cells_changed_q <= (raw_q != cells_q);
               end
               state_q <= ena_i ? DRIVE : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign scan_cols_o     = dec_y[N-1:0];
   assign x_o             = x_q;
   assign cells_o         = cells_q;
   assign cells_changed_o = cells_changed_q;
   assign frame_done_o    = (state_q == FRAME_END);
   assign busy_o          = (state_q != IDLE);
   assign state_o         = state_q;
   assign stable_cnt_o    = stable_q;

endmodule
